memcpy_engine: RTL

- Parametrised DMA-style copy engine: copies `num` words from `src` to `dest` inside one single-port synchronous RAM, one word per two clocks.
- Optional memmove semantics: overlapping ranges copy correctly, backwards where needed.
- Range checking, busy/done/error status.
- Sits between a control master (CPU/sequencer) and the shared single-port RAM (DATA_WITH x 2^ADDR_WITH, 1-cycle registered read, write on posedge when we=1).

---
 rtl/memcpy_engine.sv | 91 +++++++++
 1 files changed

// File: rtl/memcpy_engine.sv
// memcpy_engine: copies num words src->dest inside one single-port RAM, one word per two clocks,
// choosing a descending walk for forward-overlapping ranges so memmove semantics hold.
module memcpy_engine #(
   parameter int DATA_WITH = 8,
   parameter int ADDR_WITH = 8,
   parameter int LEN_WITH  = 9,
   parameter bit MEMMOVE   = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start_i,
   input  logic [ADDR_WITH-1:0] dest_i,
   input  logic [ADDR_WITH-1:0] src_i,
   input  logic [LEN_WITH-1:0]  num_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 error_o,
   output logic [ADDR_WITH-1:0] mem_addr_o,
   output logic                 mem_we_o,
   output logic                 mem_oe_o,
   output logic [DATA_WITH-1:0] mem_wdata_o,
   input  logic [DATA_WITH-1:0] mem_rdata_i
);
   typedef enum logic [2:0] {IDLE, RD, WR, FIN, ERR} state_e;
   typedef logic [LEN_WITH:0]   wide_t;
   typedef logic [LEN_WITH-1:0] len_t;
   // One bit wider than num so src+num can never wrap during the range check.
   localparam wide_t DEPTH = wide_t'(1) << ADDR_WITH;

   state_e               state_q, state_d;
   logic [ADDR_WITH-1:0] src_q, src_d, dest_q, dest_d, idx_a;
   len_t                 num_q, num_d, idx_q, idx_d;
   logic                 dir_q, dir_d, overlap, last;
   wide_t                src_end, dest_end;

   always_comb begin
      src_end  = wide_t'(src_i) + wide_t'(num_i);
      dest_end = wide_t'(dest_i) + wide_t'(num_i);
      overlap  = MEMMOVE && wide_t'(src_i) < wide_t'(dest_i) && wide_t'(dest_i) < src_end;
      last     = dir_q ? idx_q == '0 : idx_q == num_q - len_t'(1);
      idx_a    = idx_q[ADDR_WITH-1:0];
      state_d  = state_q;
      src_d    = src_q;
      dest_d   = dest_q;
      num_d    = num_q;
      idx_d    = idx_q;
      dir_d    = dir_q;
      case (state_q)
         IDLE: if (start_i) begin
            src_d   = src_i;
            dest_d  = dest_i;
            num_d   = num_i;
            dir_d   = overlap;
            idx_d   = overlap ? num_i - len_t'(1) : '0;
            state_d = (src_end > DEPTH || dest_end > DEPTH) ? ERR : (num_i == '0) ? FIN : RD;
         end
         RD: state_d = WR;
         WR: begin
            state_d = last ? FIN : RD;
            idx_d   = last ? idx_q : dir_q ? idx_q - len_t'(1) : idx_q + len_t'(1);
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy_o      = state_q != IDLE;
   assign done_o      = state_q == FIN;
   assign error_o     = state_q == ERR;
   assign mem_oe_o    = state_q == RD;
   assign mem_we_o    = state_q == WR;
   assign mem_addr_o  = mem_oe_o ? src_q + idx_a : mem_we_o ? dest_q + idx_a : '0;
   assign mem_wdata_o = mem_we_o ? mem_rdata_i : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         src_q   <= '0;
         dest_q  <= '0;
         num_q   <= '0;
         idx_q   <= '0;
         dir_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dest_q  <= dest_d;
         num_q   <= num_d;
         idx_q   <= idx_d;
         dir_q   <= dir_d;
      end
   end
endmodule
